// File: rtl/disp_arbiter.sv
// disp_arbiter: round-robin owner of the 16-bit hex display word.
// Four requesters share the display. Each owner keeps it for DWELL cycles,
// a "next" button press advances early, and a dropped request releases it.
// Optional build macro DISP_DEBOUNCE_EN adds a DEB-cycle button debounce
// filter; without it the synchronized button edge is used directly.
module disp_arbiter #(
    parameter int DWELL = 100_000_000,
    parameter int DEB   = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [63:0] data_in,
    input  logic        btn_raw,
    output logic [15:0] display,
    output logic [3:0]  grant,
    output logic [1:0]  owner,
    output logic        active
);

    localparam int CNT_W = $clog2(DWELL);

    typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       display_q, display_d;
    logic [3:0]        grant_q, grant_d;
    logic [1:0]        owner_q, owner_d;
    logic              active_q, active_d;
    logic              sync1_q, sync2_q, sync3_q;
    logic              press_q;
    logic [2:0]        pick;
    logic              advance;

    // Round-robin search: first requester after 'last', wrapping; 'last'
    // itself is checked last so a sole remaining requester is re-granted.
    // Result is {found, index}.
    function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign pick    = rr_pick(owner_q, req);
    assign advance = (cnt_q == CNT_W'(DWELL - 1)) || press_q || !req[owner_q];

    // Button synchronizer; sync3 holds the previous synchronized level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

`ifdef DISP_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB);
    logic [DEB_W-1:0] dcnt_q;
    logic             filt_q;

    // Debounce: filtered level follows only after DEB stable cycles; pulse on its rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q  <= '0;
            filt_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (sync2_q != sync3_q) begin
                dcnt_q <= '0;
            end else if (sync2_q != filt_q) begin
                if (dcnt_q == DEB_W'(DEB - 1)) begin
                    filt_q  <= sync2_q;
                    press_q <= sync2_q;
                    dcnt_q  <= '0;
                end else begin
                    dcnt_q <= dcnt_q + 1'b1;
                end
            end else begin
                dcnt_q <= '0;
            end
        end
    end
`else
    // Press pulse on the synchronized level's rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_q <= 1'b0;
        end else begin
            press_q <= sync2_q & ~sync3_q;
        end
    end
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            display_q <= 16'h0000;
            grant_q   <= 4'b0000;
            owner_q   <= 2'd3;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            display_q <= display_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            active_q  <= active_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req != 4'b0000) state_d = SHOW;
            SHOW:    if (advance && req == 4'b0000) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the dwell counter
    always_comb begin
        cnt_d     = cnt_q;
        display_d = display_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        active_d  = active_q;
        case (state_q)
            IDLE: begin
                display_d = 16'h0000;
                if (pick[2]) begin
                    owner_d  = pick[1:0];
                    grant_d  = 4'b0001 << pick[1:0];
                    active_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            SHOW: begin
                display_d = data_in[16*owner_q +: 16];
                cnt_d     = cnt_q + 1'b1;
                if (advance) begin
                    cnt_d = '0;
                    if (pick[2]) begin
                        owner_d = pick[1:0];
                        grant_d = 4'b0001 << pick[1:0];
                    end else begin
                        grant_d   = 4'b0000;
                        active_d  = 1'b0;
                        display_d = 16'h0000;
                    end
                end
            end
            default: begin
                grant_d   = 4'b0000;
                active_d  = 1'b0;
                display_d = 16'h0000;
            end
        endcase
    end

    assign display = display_q;
    assign grant   = grant_q;
    assign owner   = owner_q;
    assign active  = active_q;

endmodule

// File: doc/disp_arbiter.md
# disp_arbiter

Round-robin arbiter and sequencer that shares the 16-bit hex display word between four requesters (e.g. PC, instruction, register read data, ALU result). It grants the display to one requester at a time for a programmable dwell period, advances early on a manual button press, and drives the 16-bit word consumed by the four-digit seven-segment scanner. It sits between the CPU debug taps and the display driver, in the top-level board wrapper.

## Interface
- `DWELL`, 100_000_000 — clock cycles a requester owns the display before rotation (≥2).
- `DEB`, 1_000_000 — cycles the synchronized button must be stable to count as pressed (used only with `DISP_DEBOUNCE_EN`; ≥2).
- `clk` in 1 — system clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `req` in 4 — per-requester request level; bit i = requester i wants the display.
- `data_in` in 64 — requester i's word on `data_in[16*i+15:16*i]`.
- `btn_raw` in 1 — raw, asynchronous "next" push button, active-high.
- `display` out 16 — registered word to the display driver.
- `grant` out 4 — one-hot owner; all-zero when idle.
- `owner` out 2 — binary index of the current owner; holds last value when idle.
- `active` out 1 — high while any requester owns the display.

## Operation
- Reset values: `display`=16'h0000, `grant`=4'b0000, `owner`=2'd3, `active`=0, dwell counter 0, state IDLE, debounce/sync registers 0. `owner`=3 at reset makes the first search start at requester 0.
- States: IDLE, SHOW.
- IDLE: `display` held at 0. If `req`≠0, pick the winner by round-robin search starting at `(owner+1) mod 4`, wrapping; load `owner`/`grant`, clear the dwell counter, go to SHOW.
- SHOW: every cycle `display` ← owner's slice of `data_in`, so live values track. The dwell counter increments by 1.
- Advance event in SHOW: dwell counter == DWELL−1, a button press pulse, or `req[owner]`==0.
  - On advance, run round-robin from `(owner+1) mod 4` over the current `req`.
  - If the search finds a requester (including the current owner when it is the only one still requesting), grant it, clear the counter, and stay in SHOW.
  - If `req`==0, go to IDLE: `grant`←0, `active`←0, `display`←0, `owner` unchanged.
- Simultaneous advance causes (expiry + press + drop in the same cycle) produce exactly one rotation.
- Button: `btn_raw` passes through a 2-flop synchronizer, then produces a one-cycle press pulse on its rising edge (see Configuration). Presses in IDLE are ignored, with no queuing.
- Dwell counter is `$clog2(DWELL)` bits wide. It never exceeds DWELL−1 and wraps only via the advance clear.
- `rst_n` low at any time, including mid-dwell or mid-debounce, returns all state to reset values asynchronously. Release is sampled on the next `clk` edge.

## Timing
- `req` rising in IDLE at edge N → `grant`/`active`/`owner` valid after edge N+1. `display` shows the owner's data after edge N+2.
- In SHOW, a `data_in` change at edge N appears on `display` after edge N+1 (1-cycle latency).
- Dwell: with continuous requests, each owner holds `grant` for exactly DWELL cycles.
- Owner drops `req` before edge N → the new `grant` (or IDLE) takes effect after edge N.
- Button: a press is recognized 3 cycles after `btn_raw` rises (2 synchronizer cycles plus 1 edge-detect cycle). `grant` changes on the following edge. With debounce, add DEB cycles.
- All outputs are registered, with no combinational input-to-output paths.

## Configuration
- `DISP_DEBOUNCE_EN` defined: after synchronization, a DEB-cycle stability counter restarts on every level change. The filtered level updates only after DEB stable cycles, and the press pulse is generated on the filtered level's rising edge.
- Not defined: the press pulse is generated directly on the synchronized level's rising edge, and no counter is instantiated. `DEB` is ignored.

## Test plan
- Reset and idle: `rst_n`=0, then release with `req`=0 → `display`=0, `grant`=0, `owner`=3, `active`=0 indefinitely.
- Rotation: DWELL=8, `req`=4'b1111, slices 16'h1111/2222/3333/4444 → grant sequence 0001,0010,0100,1000,0001; each grant lasts 8 cycles; `display` matches the owner's slice one cycle after the grant.
- Skip and sole requester: `req`=4'b0101 → owners alternate 0,2,0. Then drop to `req`=4'b0100 → owner 2 is re-granted every 8 cycles, `display` stays 16'h3333.
- Drop to idle: owner 1 with `req`=4'b0010, clear `req` mid-dwell → next edge `grant`=0, `active`=0, `display`=0, `owner`=1. Re-request `req`=4'b1111 → owner 2.
- Button: DWELL=1000, `req`=4'b1111, pulse `btn_raw` for 5 cycles → single advance 3–4 cycles later. With the macro, DEB=16: a 10-cycle bounce train causes no advance; a stable 20-cycle press causes exactly one advance.
- Async reset mid-operation: assert `rst_n`=0 between clock edges during SHOW → outputs return to reset values immediately, without waiting for a `clk` edge.
